// File: rtl/game_pkg.sv
// Shared constants and types for the servo ownership logic.
// Covers arbiter state encodings, requester indices and angle limits.
package game_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LINGER = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_EV1 = 0;
    localparam int unsigned REQ_EV2 = 1;
    localparam int unsigned REQ_P2  = 2;

    localparam logic [7:0] DEFAULT_ANGLE = 8'd90;
    localparam logic [7:0] MAX_ANGLE     = 8'd180;

    // Lowest set index wins; callers only use the result when r is non-zero.
    function automatic logic [1:0] first_req(input logic [NUM_REQ-1:0] r);
        if (r[REQ_EV1]) begin
            return 2'(REQ_EV1);
        end else if (r[REQ_EV2]) begin
            return 2'(REQ_EV2);
        end
        return 2'(REQ_P2);
    endfunction

    function automatic logic [7:0] clamp_angle(input logic [7:0] a, input logic [7:0] max_a);
        return (a > max_a) ? max_a : a;
    endfunction

endpackage

// File: rtl/servo_access_arbiter_slew.sv
// Slew limiter: free-running step tick and a 1-degree-per-tick walk toward the target angle.
// settled is the registered compare of the walked angle against the target.
module servo_slew_limiter
    import game_pkg::*;
#(
    parameter int unsigned STEP_TICKS  = 50000,
    parameter logic [7:0]  RESET_ANGLE = DEFAULT_ANGLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target,
    output logic [7:0] angle_out,
    output logic       settled
);

    localparam int unsigned CntW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STEP_TICKS - 1);

    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [7:0]      angle_q, angle_d;
    logic            settled_q;

    always_comb begin
        tick       = (tick_cnt_q == CntMax);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);
        angle_d    = angle_q;
        if (tick) begin
            if (angle_q < target) begin
                angle_d = angle_q + 8'd1;
            end else if (angle_q > target) begin
                angle_d = angle_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            angle_q    <= RESET_ANGLE;
            settled_q  <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            angle_q    <= angle_d;
            settled_q  <= (angle_q == target);
        end
    end

    assign angle_out = angle_q;
    assign settled   = settled_q;

endmodule

// File: rtl/servo_access_arbiter.sv
// Fixed-priority owner of the single servo with minimum hold time and a linger window.
// The granted requester's clamped angle feeds the slew limiter as its target.
module servo_access_arbiter #(
    parameter int unsigned STEP_TICKS    = 50000,
    parameter int unsigned MIN_HOLD_CYC  = 2500000,
    parameter logic [7:0]  DEFAULT_ANGLE = game_pkg::DEFAULT_ANGLE,
    parameter logic [7:0]  MAX_ANGLE     = game_pkg::MAX_ANGLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [7:0] angle0,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    output logic [2:0] grant,
    output logic [7:0] angle_out,
    output logic       settled,
    output logic       busy
);

    import game_pkg::*;

    localparam int unsigned HoldW = (MIN_HOLD_CYC > 1) ? $clog2(MIN_HOLD_CYC) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(MIN_HOLD_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [2:0]       grant_q, grant_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [7:0]       target_q, target_d;
    logic             busy_q;
    logic [2:0]       higher;
    logic [7:0]       owner_angle;

    // Arbitration: next state, owner and hold counter.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = (hold_q == '0) ? '0 : hold_q - HoldW'(1);
        higher  = req & ((3'b001 << owner_q) - 3'b001);

        case (state_q)
            ARB_IDLE: begin
                hold_d = '0;
                if (|req) begin
                    state_d = ARB_OWNED;
                    owner_d = first_req(req);
                    hold_d  = HoldLoad;
                end
            end
            ARB_OWNED, ARB_LINGER: begin
                if (|higher) begin
                    // Preemption ignores hold and wins over a same-cycle owner drop.
                    state_d = ARB_OWNED;
                    owner_d = first_req(req);
                    hold_d  = HoldLoad;
                end else if (req[owner_q]) begin
                    state_d = ARB_OWNED;
                end else if (hold_q != '0) begin
                    state_d = ARB_LINGER;
                end else if (|req) begin
                    state_d = ARB_OWNED;
                    owner_d = first_req(req);
                    hold_d  = HoldLoad;
                end else begin
                    state_d = ARB_IDLE;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        owner_angle = angle2;
        case (owner_d)
            2'(REQ_EV1): owner_angle = angle0;
            2'(REQ_EV2): owner_angle = angle1;
            default:     owner_angle = angle2;
        endcase
    end

    // Linger keeps the last sampled target and the current grant.
    always_comb begin
        target_d = DEFAULT_ANGLE;
        grant_d  = '0;
        case (state_d)
            ARB_OWNED: begin
                target_d = clamp_angle(owner_angle, MAX_ANGLE);
                grant_d  = 3'b001 << owner_d;
            end
            ARB_LINGER: begin
                target_d = target_q;
                grant_d  = grant_q;
            end
            default: begin
                target_d = DEFAULT_ANGLE;
                grant_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            grant_q  <= '0;
            hold_q   <= '0;
            target_q <= DEFAULT_ANGLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
            target_q <= target_d;
            busy_q   <= (state_d != ARB_IDLE);
        end
    end

    servo_slew_limiter #(
        .STEP_TICKS  (STEP_TICKS),
        .RESET_ANGLE (DEFAULT_ANGLE)
    ) u_slew (
        .clk       (clk),
        .rst_n     (rst_n),
        .target    (target_q),
        .angle_out (angle_out),
        .settled   (settled)
    );

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_servo_access_arbiter.sv
// Directed bench for servo_access_arbiter with a short step period and hold time.
module tb_servo_access_arbiter;

    localparam int unsigned StepTicks = 4;
    localparam int unsigned MinHold   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] angle0 = 8'd90;
    logic [7:0] angle1 = 8'd90;
    logic [7:0] angle2 = 8'd90;
    logic [2:0] grant;
    logic [7:0] angle_out;
    logic       settled;
    logic       busy;

    int total = 0;
    int bad   = 0;

    servo_access_arbiter #(
        .STEP_TICKS   (StepTicks),
        .MIN_HOLD_CYC (MinHold)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .angle0    (angle0),
        .angle1    (angle1),
        .angle2    (angle2),
        .grant     (grant),
        .angle_out (angle_out),
        .settled   (settled),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_idle_const(input int n);
        logic [12:0] exp_v, got_v;
        exp_v = {3'b000, 8'd90, 1'b1, 1'b0};
        for (int i = 0; i < n; i++) begin
            cyc(1);
            got_v = {grant, angle_out, settled, busy};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL idle_const cycle %0d: got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        cyc(3);
        total++;
        if ({grant, angle_out, settled, busy} !== {3'b000, 8'd90, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got grant=%b angle=%0d settled=%b busy=%b want 000/90/1/0",
                     grant, angle_out, settled, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_idle_const(100);
    endtask

    task automatic watch_steps(input string name, input int n, input bit up);
        logic [7:0] prev, exp_v;
        int last, cnt, steps;
        prev  = angle_out;
        last  = -1;
        cnt   = 0;
        steps = 0;
        while (steps < n && cnt < 20 * StepTicks * n) begin
            cyc(1);
            cnt++;
            if (angle_out !== prev) begin
                exp_v = up ? prev + 8'd1 : prev - 8'd1;
                total++;
                if (angle_out !== exp_v) begin
                    bad++;
                    $display("FAIL %s step value: got %0d want %0d", name, angle_out, exp_v);
                end
                if (last >= 0) begin
                    total++;
                    if (cnt - last != StepTicks) begin
                        bad++;
                        $display("FAIL %s step spacing: got %0d want %0d", name, cnt - last,
                                 StepTicks);
                    end
                end
                last  = cnt;
                prev  = angle_out;
                steps++;
            end
        end
        if (steps < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d steps want %0d", name, steps, n);
        end
    endtask

    task automatic go_idle();
        int cnt;
        req = 3'b000;
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (grant !== 3'b000 && cnt < 30);
        total++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL go_idle: got grant=%b busy=%b want 000/0", grant, busy);
        end
    endtask

    task automatic test_slew_up();
        angle2 = 8'd94;
        req    = 3'b100;
        cyc(1);
        total++;
        if (grant !== 3'b100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL slew_up grant: got %b busy=%b want 100/1", grant, busy);
        end
        watch_steps("slew_up", 4, 1'b1);
        total++;
        if (angle_out !== 8'd94 || settled !== 1'b0) begin
            bad++;
            $display("FAIL slew_up arrive: got angle=%0d settled=%b want 94/0", angle_out, settled);
        end
        cyc(1);
        total++;
        if (settled !== 1'b1) begin
            bad++;
            $display("FAIL slew_up settled_lag: got %b want 1", settled);
        end
        cyc(12);
        total++;
        if (angle_out !== 8'd94 || settled !== 1'b1) begin
            bad++;
            $display("FAIL slew_up hold: got angle=%0d settled=%b want 94/1", angle_out, settled);
        end
    endtask

    task automatic setup_preempt();
        angle2 = 8'd120;
        req    = 3'b100;
        cyc(3);
        angle0 = 8'd30;
        req    = 3'b101;
        cyc(1);
        total++;
        if (grant !== 3'b001) begin
            bad++;
            $display("FAIL preempt grant: got %b want 001", grant);
        end
    endtask

    task automatic test_preempt();
        go_idle();
        setup_preempt();
        watch_steps("preempt_descend", 3, 1'b0);
        // Second pass: reload shows up as a full-length linger after the owner drops.
        go_idle();
        setup_preempt();
        req = 3'b100;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] exp_g;
            cyc(1);
            exp_g = (k < 10) ? 3'b001 : 3'b100;
            total++;
            if (grant !== exp_g) begin
                bad++;
                $display("FAIL preempt_reload k=%0d: got %b want %b", k, grant, exp_g);
            end
        end
    endtask

    task automatic test_linger();
        int cnt;
        go_idle();
        cnt = 0;
        while (!(angle_out === 8'd90 && settled === 1'b1) && cnt < 1000) begin
            cyc(1);
            cnt++;
        end
        total++;
        if (angle_out !== 8'd90 || settled !== 1'b1) begin
            bad++;
            $display("FAIL linger_prep: got angle=%0d settled=%b want 90/1", angle_out, settled);
        end
        angle1 = 8'd90;
        req    = 3'b010;
        cyc(1);
        total++;
        if (grant !== 3'b010) begin
            bad++;
            $display("FAIL linger grant: got %b want 010", grant);
        end
        cyc(2);
        req    = 3'b100;
        angle1 = 8'd100;
        for (int k = 3; k <= 12; k++) begin
            logic [2:0] exp_g;
            cyc(1);
            exp_g = (k < 10) ? 3'b010 : 3'b100;
            total++;
            if (grant !== exp_g) begin
                bad++;
                $display("FAIL linger k=%0d: got %b want %b", k, grant, exp_g);
            end
            if (k < 10) begin
                total++;
                if (angle_out !== 8'd90 || settled !== 1'b1) begin
                    bad++;
                    $display("FAIL linger_frozen k=%0d: got angle=%0d settled=%b want 90/1",
                             k, angle_out, settled);
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] max_seen;
        go_idle();
        angle1 = 8'd250;
        req    = 3'b010;
        cyc(1);
        total++;
        if (grant !== 3'b010) begin
            bad++;
            $display("FAIL clamp grant: got %b want 010", grant);
        end
        max_seen = angle_out;
        for (int i = 0; i < 800; i++) begin
            cyc(1);
            if (angle_out > max_seen) max_seen = angle_out;
        end
        total++;
        if (max_seen > 8'd180) begin
            bad++;
            $display("FAIL clamp_max: got %0d want <=180", max_seen);
        end
        total++;
        if (angle_out !== 8'd180 || settled !== 1'b1) begin
            bad++;
            $display("FAIL clamp_final: got angle=%0d settled=%b want 180/1", angle_out, settled);
        end
    endtask

    task automatic test_reset_mid_slew();
        int cnt;
        angle0 = 8'd0;
        req    = 3'b011;
        cnt    = 0;
        while (angle_out !== 8'd57 && cnt < 1000) begin
            cyc(1);
            cnt++;
        end
        total++;
        if (angle_out !== 8'd57 || grant !== 3'b001) begin
            bad++;
            $display("FAIL mid_slew_reach: got angle=%0d grant=%b want 57/001", angle_out, grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({grant, angle_out, settled, busy} !== {3'b000, 8'd90, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got grant=%b angle=%0d settled=%b busy=%b want 000/90/1/0",
                     grant, angle_out, settled, busy);
        end
        req = 3'b000;
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        test_idle_const(20);
        test_slew_up();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slew_up();
        test_preempt();
        test_linger();
        test_clamp();
        test_reset_mid_slew();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
